// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubble insertion, data-memory
// wait stalls, branch flush, sticky memory timeout and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             PCWrite,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             MEM_WB_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  // state    | meaning
  // RUN      | normal issue; load-use hazards are checked here
  // LU_STALL | one bubble already inserted for a load-use; hazard ignored
  // MEM_WAIT | data memory has not completed; front of pipe frozen
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  localparam int WW = $clog2(MAX_WAIT + 2);

  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             mem_miss, lu_hazard;

  always_comb begin
    mem_miss  = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~mem_ready;
    lu_hazard = ID_EX_MemRead & (ID_EX_Rt != 5'd0) &
                ((ID_EX_Rt == IF_ID_Rs) | (ID_EX_Rt == IF_ID_Rt));
  end

  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_en      = 1'b1;
    ID_EX_en      = 1'b1;
    EX_MEM_en     = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_bubble  = 1'b0;
    MEM_WB_bubble = 1'b0;
    state_d       = RUN;
    if (rst) begin
      // Hold PC while every register loads a bubble
      PCWrite       = 1'b0;
      IF_ID_flush   = 1'b1;
      ID_EX_bubble  = 1'b1;
      MEM_WB_bubble = 1'b1;
    end else if (mem_miss) begin
      PCWrite       = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EX_en      = 1'b0;
      EX_MEM_en     = 1'b0;
      MEM_WB_bubble = 1'b1;
      state_d       = MEM_WAIT;
    end else if (branch_taken) begin
      IF_ID_flush   = 1'b1;
      ID_EX_bubble  = 1'b1;
    end else if ((state_q == RUN) && lu_hazard) begin
      PCWrite       = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EX_bubble  = 1'b1;
      state_d       = LU_STALL;
    end
  end

  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    if (state_q == MEM_WAIT) begin
      wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);
      if (wait_d == WW'(MAX_WAIT)) timeout_d = 1'b1;
    end
    stall_d = stall_q;
    if (!PCWrite && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, the MEM_WAIT cycle count at which mem_timeout sets.
REQ-002 SHALL have parameter CNT_W, default 16, the width of stall_cycles.
REQ-003 SHALL have ports, one per line:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_Rt  input  5  load destination register.
- IF_ID_Rs, IF_ID_Rt  input  5 each  source registers of the instruction in ID.
- EX_MEM_MemRead, EX_MEM_MemWrite  input  1 each  memory access in MEM stage.
- mem_ready  input  1  data memory completes its access this cycle.
- branch_taken  input  1  branch resolved taken in EX.
- PCWrite  output  1  PC update enable.
- IF_ID_en, ID_EX_en, EX_MEM_en  output  1 each  pipeline-register load enables.
- IF_ID_flush  output  1  clear IF/ID to a NOP.
- ID_EX_bubble, MEM_WB_bubble  output  1 each  zero the control fields loaded into that register.
- mem_timeout  output  1  sticky memory-wait error.
- stall_cycles  output  CNT_W  saturating count of cycles with PCWrite=0.

Function
REQ-004 SHALL implement FSM states RUN, LU_STALL and MEM_WAIT, registered on clk.
REQ-005 SHALL make the control outputs (PCWrite, enables, flush, bubbles) combinational from the current state and inputs.
REQ-006 SHALL define mem_miss = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~mem_ready.
REQ-007 SHALL define lu_hazard = ID_EX_MemRead & (ID_EX_Rt != 0) & (ID_EX_Rt == IF_ID_Rs | ID_EX_Rt == IF_ID_Rt).
REQ-008 SHALL apply priority per cycle: mem_miss, then branch_taken, then lu_hazard (evaluated in RUN only), then normal.
REQ-009 SHALL, on mem_miss in any state, drive PCWrite=IF_ID_en=ID_EX_en=EX_MEM_en=0, MEM_WB_bubble=1, flush=0, ID_EX_bubble=0, and go to (or stay in) MEM_WAIT.
REQ-010 SHALL, in MEM_WAIT with mem_ready=1, drive normal outputs for that cycle and return to RUN; a branch_taken in that cycle is honoured per REQ-011.
REQ-011 SHALL, on branch_taken without mem_miss, drive all enables=1, PCWrite=1, IF_ID_flush=1, ID_EX_bubble=1, and go to RUN.
REQ-012 SHALL, on lu_hazard in RUN without mem_miss or branch_taken, drive PCWrite=0, IF_ID_en=0, ID_EX_en=1, ID_EX_bubble=1, EX_MEM_en=1, and go to LU_STALL.
REQ-013 SHALL ignore lu_hazard in LU_STALL, drive normal outputs there, and return to RUN after exactly one cycle (single bubble per load-use).
REQ-014 SHALL define normal as all enables=1, PCWrite=1, flush=0 and bubbles=0.
REQ-015 SHALL keep a wait counter that clears on MEM_WAIT entry and increments each cycle in MEM_WAIT.
REQ-016 SHALL set mem_timeout when the wait counter reaches MAX_WAIT; mem_timeout SHALL stay 1 until rst and SHALL NOT alter the stall behaviour.
REQ-017 SHALL increment stall_cycles each cycle with PCWrite=0 and saturate it at all-ones without wrapping.

Reset
REQ-018 SHALL, on rst=1 at posedge, set state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0.
REQ-019 SHALL, while rst=1, drive PCWrite=0, all enables=1, IF_ID_flush=1, ID_EX_bubble=1 and MEM_WB_bubble=1, so that bubbles fill the pipeline.
REQ-020 SHALL abandon MEM_WAIT or LU_STALL immediately when rst asserts mid-operation.

Verification
REQ-021 SHALL cover: ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 -> one cycle PCWrite=0, ID_EX_bubble=1, then normal; stall_cycles=1.
REQ-022 SHALL cover: ID_EX_Rt=0 matching IF_ID_Rs=0 with a load in EX -> no stall.
REQ-023 SHALL cover: EX_MEM_MemRead=1 with mem_ready low for 3 cycles -> enables=0 and MEM_WB_bubble=1 for 3 cycles, normal on the 4th; stall_cycles=3.
REQ-024 SHALL cover: mem_ready low for 16 cycles, MAX_WAIT=15 -> mem_timeout=1 and held after mem_ready rises until rst.
REQ-025 SHALL cover: branch_taken with lu_hazard the same cycle -> IF_ID_flush=1, PCWrite=1, state stays RUN; branch_taken with mem_miss -> mem stall wins.
REQ-026 SHALL cover: rst asserted during MEM_WAIT -> next cycle state RUN, counters 0, outputs per REQ-019 while rst=1.
